// File: rtl/alu_ctrl_pipe.sv
// ALU control pipeline stage.
// Decodes aluop/funct in ID and registers the result into EX. The EX register
// supports hold (stall_in), flush and hazard bubbles. A small MULT/DIV
// sequencer tracks the busy time of the multi-cycle unit. Its activity drives
// an ID-stage HI/LO hazard stall.
//
// Handshake / pipeline semantics (one place for all of it):
//   - The ID stage presents an instruction when id_valid=1. The instruction is
//     consumed on a rising edge only when stall_in=0, flush=0 and stall_out=0.
//   - stall_out=1 means ID must hold its instruction. The EX register loads a
//     bubble in that cycle (unless stall_in holds EX).
//   - stall_in=1 freezes every EX field. md_start is never re-issued for an
//     op that is being held.
//   - md_start pulses for exactly one cycle when a valid MULT/DIV enters EX.
//     md_busy then stays high for N cycles, and md_done marks the last of them.
module alu_ctrl_pipe #(
   parameter int CTRL_W     = 5,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              id_valid,
   input  logic [2:0]        id_aluop,
   input  logic [5:0]        id_funct,
   input  logic              stall_in,
   input  logic              flush,
   output logic              stall_out,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_alucontrol,
   output logic              ex_shamt_sel,
   output logic              ex_illegal,
   output logic              md_start,
   output logic              md_busy,
   output logic              md_done
);

   // ALU operation codes (5-bit native encoding, zero-extended on output)
   localparam logic [4:0] C_AND   = 5'b00000;
   localparam logic [4:0] C_OR    = 5'b00001;
   localparam logic [4:0] C_ADD   = 5'b00010;
   localparam logic [4:0] C_XOR   = 5'b00011;
   localparam logic [4:0] C_NOR   = 5'b00100;
   localparam logic [4:0] C_SUB   = 5'b00110;
   localparam logic [4:0] C_SLT   = 5'b00111;
   localparam logic [4:0] C_SLL   = 5'b01000;
   localparam logic [4:0] C_SRL   = 5'b01001;
   localparam logic [4:0] C_SRA   = 5'b01010;
   localparam logic [4:0] C_SLTU  = 5'b01011;
   localparam logic [4:0] C_LUI   = 5'b01100;
   localparam logic [4:0] C_MULT  = 5'b10000;
   localparam logic [4:0] C_MULTU = 5'b10001;
   localparam logic [4:0] C_DIV   = 5'b10010;
   localparam logic [4:0] C_DIVU  = 5'b10011;
   localparam logic [4:0] C_MFHI  = 5'b10100;
   localparam logic [4:0] C_MFLO  = 5'b10101;
   localparam logic [4:0] C_MTHI  = 5'b10110;
   localparam logic [4:0] C_MTLO  = 5'b10111;
   localparam logic [4:0] C_NOP   = 5'b11111;

   // Sequencer states
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // The counter only has to hold N-1 for the longer of the two operations
   localparam int MAX_N = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
   localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   // ID-stage decode results
   logic [4:0]       dec_code;
   logic             dec_shamt_sel;
   logic             dec_illegal;
   logic             dec_md;
   logic             dec_hilo;

   // EX-stage registers
   logic [4:0]       ex_code;
   logic             md_start_q;

   // Sequencer registers
   logic [0:0]       md_state;
   logic [CNT_W-1:0] md_cnt;

   // Decode aluop, and funct for R-type, into an ALU code plus side flags
   always_comb begin
      dec_code      = C_NOP;
      dec_shamt_sel = 1'b0;
      dec_illegal   = 1'b0;
      case (id_aluop)
         3'b000: dec_code = C_ADD;
         3'b001: dec_code = C_SUB;
         3'b010: begin
            case (id_funct)
               6'b100000,
               6'b100001: dec_code = C_ADD;
               6'b100010,
               6'b100011: dec_code = C_SUB;
               6'b100100: dec_code = C_AND;
               6'b100101: dec_code = C_OR;
               6'b100110: dec_code = C_XOR;
               6'b100111: dec_code = C_NOR;
               6'b101010: dec_code = C_SLT;
               6'b101011: dec_code = C_SLTU;
               6'b000000: begin
                  dec_code      = C_SLL;
                  dec_shamt_sel = 1'b1;
               end
               6'b000010: begin
                  dec_code      = C_SRL;
                  dec_shamt_sel = 1'b1;
               end
               6'b000011: begin
                  dec_code      = C_SRA;
                  dec_shamt_sel = 1'b1;
               end
               6'b000100: dec_code = C_SLL;
               6'b000110: dec_code = C_SRL;
               6'b000111: dec_code = C_SRA;
               6'b011000: dec_code = C_MULT;
               6'b011001: dec_code = C_MULTU;
               6'b011010: dec_code = C_DIV;
               6'b011011: dec_code = C_DIVU;
               6'b010000: dec_code = C_MFHI;
               6'b010010: dec_code = C_MFLO;
               6'b010001: dec_code = C_MTHI;
               6'b010011: dec_code = C_MTLO;
               default: begin
                  dec_code    = C_NOP;
                  dec_illegal = 1'b1;
               end
            endcase
         end
         3'b011: dec_code = C_OR;
         3'b100: dec_code = C_AND;
         3'b101: dec_code = C_XOR;
         3'b110: dec_code = C_SLT;
         3'b111: dec_code = C_LUI;
         default: dec_code = C_NOP;
      endcase
   end

   // MULT/MULTU/DIV/DIVU occupy 100xx; every HI/LO user occupies 10xxx
   assign dec_md   = (dec_code[4:2] == 3'b100);
   assign dec_hilo = (dec_code[4:3] == 2'b10);

   // Sequencer status, visible to the outside and to the hazard logic
   assign md_busy = (md_state == ST_BUSY);
   assign md_done = md_busy && (md_cnt == '0);

   // HI/LO hazard: a HI/LO user in ID waits while the unit is issued or busy
   assign stall_out = id_valid && dec_hilo && (md_start_q || md_busy);

   // EX register: reset > hold > flush/hazard bubble > load from ID
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ex_valid     <= 1'b0;
         ex_code      <= C_NOP;
         ex_shamt_sel <= 1'b0;
         ex_illegal   <= 1'b0;
         md_start_q   <= 1'b0;
      end else if (stall_in) begin
         // contents held; an op already issued must not be issued again
         md_start_q   <= 1'b0;
      end else if (flush || stall_out) begin
         ex_valid     <= 1'b0;
         ex_code      <= C_NOP;
         ex_shamt_sel <= 1'b0;
         ex_illegal   <= 1'b0;
         md_start_q   <= 1'b0;
      end else begin
         ex_valid     <= id_valid;
         ex_code      <= dec_code;
         ex_shamt_sel <= dec_shamt_sel;
         ex_illegal   <= dec_illegal;
         md_start_q   <= id_valid && dec_md;
      end
   end

   // MULT/DIV sequencer: counts N busy cycles after each issue, ignoring stalls and flushes
   always_ff @(posedge clk) begin
      if (!resetn) begin
         md_state <= ST_IDLE;
         md_cnt   <= '0;
      end else begin
         case (md_state)
            ST_IDLE: begin
               if (md_start_q) begin
                  md_state <= ST_BUSY;
                  // the issued op is still in EX; bit 1 separates DIV* from MULT*
                  if (ex_code[1])
                     md_cnt <= CNT_W'(DIV_CYCLES - 1);
                  else
                     md_cnt <= CNT_W'(MUL_CYCLES - 1);
               end
            end
            ST_BUSY: begin
               if (md_cnt == '0)
                  md_state <= ST_IDLE;
               else
                  md_cnt <= md_cnt - 1'b1;
            end
            default: begin
               md_state <= ST_IDLE;
               md_cnt   <= '0;
            end
         endcase
      end
   end

   assign md_start      = md_start_q;
   assign ex_alucontrol = CTRL_W'(ex_code);

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe.
// A timeline model predicts every output each cycle. Directed sequences add
// literal expectations for the key scenarios.
module tb_alu_ctrl_pipe;

   localparam int CW   = 5;
   localparam int MULN = 4;
   localparam int DIVN = 32;

   // clock / reset / DUT signals
   logic          clk = 1'b0;
   logic          resetn;
   logic          id_valid;
   logic [2:0]    id_aluop;
   logic [5:0]    id_funct;
   logic          stall_in;
   logic          flush;
   logic          stall_out;
   logic          ex_valid;
   logic [CW-1:0] ex_alucontrol;
   logic          ex_shamt_sel;
   logic          ex_illegal;
   logic          md_start;
   logic          md_busy;
   logic          md_done;

   always #5 clk = ~clk;

   alu_ctrl_pipe #(
      .CTRL_W    (CW),
      .MUL_CYCLES(MULN),
      .DIV_CYCLES(DIVN)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .id_valid     (id_valid),
      .id_aluop     (id_aluop),
      .id_funct     (id_funct),
      .stall_in     (stall_in),
      .flush        (flush),
      .stall_out    (stall_out),
      .ex_valid     (ex_valid),
      .ex_alucontrol(ex_alucontrol),
      .ex_shamt_sel (ex_shamt_sel),
      .ex_illegal   (ex_illegal),
      .md_start     (md_start),
      .md_busy      (md_busy),
      .md_done      (md_done)
   );

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- decode tables ----------------
   int tab_code[64];
   bit tab_sh[64];
   bit tab_ill[64];
   int op_code[8];

   task automatic put(input logic [5:0] f, input int code, input bit sh);
      tab_code[f] = code;
      tab_sh[f]   = sh;
      tab_ill[f]  = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         tab_code[i] = 31;
         tab_sh[i]   = 1'b0;
         tab_ill[i]  = 1'b1;
      end
      put(6'b100000, 2, 0);  put(6'b100001, 2, 0);
      put(6'b100010, 6, 0);  put(6'b100011, 6, 0);
      put(6'b100100, 0, 0);  put(6'b100101, 1, 0);
      put(6'b100110, 3, 0);  put(6'b100111, 4, 0);
      put(6'b101010, 7, 0);  put(6'b101011, 11, 0);
      put(6'b000000, 8, 1);  put(6'b000010, 9, 1);  put(6'b000011, 10, 1);
      put(6'b000100, 8, 0);  put(6'b000110, 9, 0);  put(6'b000111, 10, 0);
      put(6'b011000, 16, 0); put(6'b011001, 17, 0);
      put(6'b011010, 18, 0); put(6'b011011, 19, 0);
      put(6'b010000, 20, 0); put(6'b010010, 21, 0);
      put(6'b010001, 22, 0); put(6'b010011, 23, 0);
      op_code[0] = 2;  op_code[1] = 6;  op_code[2] = 31; op_code[3] = 1;
      op_code[4] = 0;  op_code[5] = 3;  op_code[6] = 7;  op_code[7] = 12;
   end

   function automatic int id_code(input logic [2:0] a, input logic [5:0] f);
      return (a == 3'd2) ? tab_code[f] : op_code[a];
   endfunction

   // ---------------- timeline model ----------------
   int cyc = 0;
   bit exp_valid = 1'b0;
   int exp_code = 31;
   bit exp_sh = 1'b0;
   bit exp_ill = 1'b0;
   bit exp_start = 1'b0;
   int md_s = -1;   // cycle index in which md_start was seen
   int md_n = 0;

   function automatic bit busy_at(input int c);
      return (md_s >= 0) && (c > md_s) && (c <= md_s + md_n);
   endfunction

   function automatic bit done_at(input int c);
      return (md_s >= 0) && (c == md_s + md_n);
   endfunction

   function automatic bit stall_exp();
      int c;
      c = id_code(id_aluop, id_funct);
      return id_valid && (c >= 16) && (c <= 23) && (exp_start || busy_at(cyc));
   endfunction

   initial begin : model
      int c;
      bit st;
      forever begin
         @(posedge clk);
         c  = id_code(id_aluop, id_funct);
         st = stall_exp();
         if (!resetn) begin
            exp_valid = 1'b0; exp_code = 31; exp_sh = 1'b0; exp_ill = 1'b0;
            exp_start = 1'b0; md_s = -1;
         end else begin
            if (exp_start) begin
               md_s = cyc;
               md_n = (exp_code == 18 || exp_code == 19) ? DIVN : MULN;
            end
            if (stall_in) begin
               exp_start = 1'b0;
            end else if (flush || st) begin
               exp_valid = 1'b0; exp_code = 31; exp_sh = 1'b0; exp_ill = 1'b0;
               exp_start = 1'b0;
            end else begin
               exp_valid = id_valid;
               exp_code  = c;
               exp_sh    = (id_aluop == 3'd2) ? tab_sh[id_funct] : 1'b0;
               exp_ill   = (id_aluop == 3'd2) ? tab_ill[id_funct] : 1'b0;
               exp_start = id_valid && (c >= 16) && (c <= 19);
            end
         end
         cyc++;
      end
   end

   // compare process: every output, every cycle, on the falling edge
   initial begin : compare
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("m_ex_valid",  ex_valid,      exp_valid);
            chk("m_ex_code",   ex_alucontrol, exp_code);
            chk("m_shamt_sel", ex_shamt_sel,  exp_sh);
            chk("m_illegal",   ex_illegal,    exp_ill);
            chk("m_md_start",  md_start,      exp_start);
            chk("m_md_busy",   md_busy,       busy_at(cyc));
            chk("m_md_done",   md_done,       done_at(cyc));
            chk("m_stall_out", stall_out,     stall_exp());
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input bit v, input logic [2:0] a, input logic [5:0] f);
      id_valid = v;
      id_aluop = a;
      id_funct = f;
   endtask

   initial begin : driver
      int st_cnt, busy_cnt, start_cnt, done_cnt, done_k, first_mflo, done_seen;
      resetn = 1'b0; stall_in = 1'b0; flush = 1'b0;
      set_id(0, 3'd0, 6'd0);

      // reset for two cycles
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_code",  ex_alucontrol, 31);
      chk("rst_md_busy",  md_busy, 0);
      chk("rst_stall",    stall_out, 0);
      resetn = 1'b1;

      // R-type sequence: NOR, SRA (shamt), SRL (variable)
      set_id(1, 3'd2, 6'b100111); tick();
      chk("nor_code", ex_alucontrol, 5'b00100); chk("nor_sh", ex_shamt_sel, 0);
      chk("nor_valid", ex_valid, 1);
      set_id(1, 3'd2, 6'b000011); tick();
      chk("sra_code", ex_alucontrol, 5'b01010); chk("sra_sh", ex_shamt_sel, 1);
      set_id(1, 3'd2, 6'b000110); tick();
      chk("srl_code", ex_alucontrol, 5'b01001); chk("srl_sh", ex_shamt_sel, 0);
      set_id(1, 3'd2, 6'b111111); tick();
      chk("ill_code", ex_alucontrol, 5'b11111); chk("ill_flag", ex_illegal, 1);
      set_id(1, 3'd5, 6'b111111); tick();
      chk("xor_code", ex_alucontrol, 5'b00011); chk("xor_ill", ex_illegal, 0);
      set_id(1, 3'd7, 6'd0); tick();
      chk("lui_code", ex_alucontrol, 5'b01100);

      // MULT followed by MFLO
      set_id(1, 3'd2, 6'b011000); tick();
      chk("mult_start", md_start, 1);
      set_id(1, 3'd2, 6'b010010);
      #1;
      st_cnt = 0; busy_cnt = 0; start_cnt = 0; done_cnt = 0; done_k = -1; first_mflo = -1;
      for (int k = 0; k < 10; k++) begin
         if (stall_out) st_cnt++;
         if (md_busy) busy_cnt++;
         if (md_start) start_cnt++;
         if (md_done) begin done_cnt++; done_k = k; end
         if (first_mflo < 0 && ex_valid && ex_alucontrol == 5'b10101) first_mflo = k;
         tick();
      end
      chk("mul_stall_cycles", st_cnt, 5);
      chk("mul_busy_cycles",  busy_cnt, 4);
      chk("mul_start_cycles", start_cnt, 1);
      chk("mul_done_count",   done_cnt, 1);
      chk("mul_done_cycle",   done_k, 4);
      chk("mflo_reach_ex",    first_mflo, 6);

      // stall_in holds ADD, then flush bubbles
      set_id(1, 3'd0, 6'd0); tick();
      chk("add_code", ex_alucontrol, 5'b00010);
      set_id(1, 3'd1, 6'd0); stall_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("hold_code", ex_alucontrol, 5'b00010);
         chk("hold_valid", ex_valid, 1);
      end
      stall_in = 1'b0; flush = 1'b1; tick();
      chk("flush_valid", ex_valid, 0);
      chk("flush_code", ex_alucontrol, 31);
      flush = 1'b0;

      // MULTU held by stall_in: no second md_start; stall_in and stall_out together
      set_id(1, 3'd2, 6'b011001); tick();
      chk("multu_start", md_start, 1);
      stall_in = 1'b1; set_id(1, 3'd2, 6'b010000);
      #1;
      chk("both_stall_out", stall_out, 1);
      tick();
      chk("held_no_start", md_start, 0);
      chk("held_code", ex_alucontrol, 5'b10001);
      chk("held_busy", md_busy, 1);
      tick();
      stall_in = 1'b0; set_id(0, 3'd0, 6'd0);
      for (int k = 0; k < 6; k++) tick();

      // DIV aborted by reset on its 10th busy cycle
      set_id(1, 3'd2, 6'b011010); tick();
      chk("div_start", md_start, 1);
      set_id(0, 3'd0, 6'd0);
      done_seen = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (md_done) done_seen++;
      end
      chk("div_busy_10", md_busy, 1);
      resetn = 1'b0; tick();
      chk("div_abort_busy", md_busy, 0);
      chk("div_abort_valid", ex_valid, 0);
      resetn = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (md_done) done_seen++;
      end
      chk("div_no_done", done_seen, 0);

      // full funct sweep and aluop sweep, checked by the model
      for (int f = 0; f < 64; f++) begin
         set_id(1, 3'd2, 6'(f));
         tick();
      end
      for (int a = 0; a < 8; a++) begin
         set_id((a % 2) == 0, 3'(a), 6'b100000);
         tick();
      end
      set_id(0, 3'd0, 6'd0);
      for (int k = 0; k < 40; k++) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
